// File: rtl/rx_rd_commit_ctrl.sv
// rx_rd_commit_ctrl: in-order commit scheduler for the RX buffer read pointer.
// Tags outstanding frame reads, accepts completions in any order, retires them
// in allocation order and pushes batched read-address advances to the
// read-address synchronizer no faster than it can absorb them.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   alloc_req/gnt/tag     tag allocation (grant is combinational, tag = wr ptr)
//   alloc_end_addr        buffer address just past the allocated frame
//   done_valid/done_tag   completion of an outstanding read (any order)
//   flush                 pulse: commit retired advance as soon as allowed
//   commited_rd_address   committed read address toward the synchronizer
//   outstanding           number of occupied table entries
//   proto_err             sticky: completion for an idle or already-done tag
//   commit_cnt, max_wait  commit statistics, only with RX_COMMIT_STATS_EN
//
// Address width is `BF+1 (`BF normally comes from includes.v; a 16-bit
// default is provided when it is not already defined).
// Optional macro: RX_COMMIT_STATS_EN adds commit_cnt and max_wait.

`ifndef BF
`define BF 15
`endif

module rx_rd_commit_ctrl #(
    parameter int TAG_W        = 2,
    parameter int BATCH_THRESH = 64,
    parameter int TIMEOUT      = 255,
    parameter int MIN_GAP      = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             alloc_req,
    input  logic [`BF:0]     alloc_end_addr,
    output logic             alloc_gnt,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             done_valid,
    input  logic [TAG_W-1:0] done_tag,
    input  logic             flush,
    output logic [`BF:0]     commited_rd_address,
    output logic [TAG_W:0]   outstanding,
    output logic             proto_err
`ifdef RX_COMMIT_STATS_EN
    ,
    output logic [31:0]      commit_cnt,
    output logic [15:0]      max_wait
`endif
);

    localparam int AW    = `BF + 1;
    localparam int NT    = 1 << TAG_W;
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    localparam logic [TAG_W:0]   CNT_FULL = (TAG_W + 1)'(NT);
    localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W + 1)'(1);
    localparam logic [TAG_W-1:0] PTR_ONE  = TAG_W'(1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MIN_GAP - 1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [AW-1:0]    THRESH   = AW'(BATCH_THRESH);

    typedef enum logic {
        IDLE,
        GAP
    } state_t;

    // Tag table and pointers
    logic [NT-1:0]    ent_valid;
    logic [NT-1:0]    ent_done;
    logic [AW-1:0]    ent_addr [NT];
    logic [TAG_W-1:0] wr_ptr;
    logic [TAG_W-1:0] rd_ptr;
    logic [TAG_W:0]   count;
    logic [AW-1:0]    staged_addr;
    logic             err_q;

    logic full;
    logic done_ok;
    logic retire;

    // Commit scheduler
    state_t           state;
    state_t           state_nx;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_nx;
    logic [GAP_W-1:0] gap;
    logic [GAP_W-1:0] gap_nx;
    logic             flush_pending;
    logic             fp_nx;
    logic [AW-1:0]    commit_q;
    logic [AW-1:0]    commit_nx;
    logic [AW-1:0]    diff;
    logic             diff_nz;
    logic             fire;

    assign full      = (count == CNT_FULL);
    assign alloc_gnt = alloc_req & ~full;
    assign alloc_tag = wr_ptr;

    // A completion is accepted only for a live entry not yet marked done.
    assign done_ok = done_valid & ent_valid[done_tag] & ~ent_done[done_tag];

    // Retire looks at registered state only, so a completion for the head
    // entry shows up in staged_addr one cycle later.
    assign retire = ent_valid[rd_ptr] & ent_done[rd_ptr];

    assign outstanding         = count;
    assign proto_err           = err_q;
    assign commited_rd_address = commit_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ent_valid   <= '0;
            ent_done    <= '0;
            for (int i = 0; i < NT; i++) begin
                ent_addr[i] <= '0;
            end
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            staged_addr <= '0;
            err_q       <= 1'b0;
        end else begin
            // Alloc slot is never the retiring slot: that would need full.
            if (alloc_gnt) begin
                ent_valid[wr_ptr] <= 1'b1;
                ent_done[wr_ptr]  <= 1'b0;
                ent_addr[wr_ptr]  <= alloc_end_addr;
                wr_ptr            <= wr_ptr + PTR_ONE;
            end
            if (done_ok) begin
                ent_done[done_tag] <= 1'b1;
            end
            if (done_valid && !done_ok) begin
                err_q <= 1'b1;
            end
            if (retire) begin
                ent_valid[rd_ptr] <= 1'b0;
                ent_done[rd_ptr]  <= 1'b0;
                staged_addr       <= ent_addr[rd_ptr];
                rd_ptr            <= rd_ptr + PTR_ONE;
            end
            unique case ({alloc_gnt, retire})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Modular distance; the buffer address wraps.
    assign diff    = staged_addr - commit_q;
    assign diff_nz = |diff;
    assign fire    = (state == IDLE) & diff_nz &
                     ((diff >= THRESH) | (timer == TMR_MAX) | flush_pending);

    always_comb begin
        state_nx  = state;
        timer_nx  = timer;
        gap_nx    = gap;
        fp_nx     = flush_pending | flush;
        commit_nx = commit_q;
        unique case (state)
            IDLE: begin
                if (fire) begin
                    commit_nx = staged_addr;
                    timer_nx  = '0;
                    gap_nx    = '0;
                    fp_nx     = 1'b0;
                    state_nx  = GAP;
                end else if (diff_nz) begin
                    if (timer != TMR_MAX) begin
                        timer_nx = timer + TMR_ONE;
                    end
                end else begin
                    // Nothing to commit: a pending flush has nothing to do.
                    timer_nx = '0;
                    fp_nx    = 1'b0;
                end
            end
            GAP: begin
                timer_nx = '0;
                gap_nx   = gap + GAP_ONE;
                if (gap == GAP_LAST) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            timer         <= '0;
            gap           <= '0;
            flush_pending <= 1'b0;
            commit_q      <= '0;
        end else begin
            state         <= state_nx;
            timer         <= timer_nx;
            gap           <= gap_nx;
            flush_pending <= fp_nx;
            commit_q      <= commit_nx;
        end
    end

`ifdef RX_COMMIT_STATS_EN
    logic [31:0] timer_w;
    logic [15:0] wait_sat;

    assign timer_w  = 32'(timer);
    assign wait_sat = (timer_w > 32'h0000_FFFF) ? 16'hFFFF : timer_w[15:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            commit_cnt <= '0;
            max_wait   <= '0;
        end else if (fire) begin
            commit_cnt <= commit_cnt + 32'd1;
            if (wait_sat > max_wait) begin
                max_wait <= wait_sat;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rx_rd_commit_ctrl.sv
// tb_rx_rd_commit_ctrl: directed and random stimulus against a queue-based
// reference model; expected commits are scoreboarded and checked by a monitor.

`ifndef BF
`define BF 15
`endif

module tb_rx_rd_commit_ctrl;

    localparam int AW = `BF + 1;
    localparam int NT = 4;

    typedef logic [AW-1:0] addr_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        alloc_req;
    addr_t       alloc_end_addr;
    logic        alloc_gnt;
    logic [1:0]  alloc_tag;
    logic        done_valid;
    logic [1:0]  done_tag;
    logic        flush;
    addr_t       commited_rd_address;
    logic [2:0]  outstanding;
    logic        proto_err;
`ifdef RX_COMMIT_STATS_EN
    logic [31:0] commit_cnt;
    logic [15:0] max_wait;
`endif

    always #5 clk = ~clk;

    rx_rd_commit_ctrl #(
        .TAG_W(2), .BATCH_THRESH(64), .TIMEOUT(255), .MIN_GAP(8)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .alloc_req           (alloc_req),
        .alloc_end_addr      (alloc_end_addr),
        .alloc_gnt           (alloc_gnt),
        .alloc_tag           (alloc_tag),
        .done_valid          (done_valid),
        .done_tag            (done_tag),
        .flush               (flush),
        .commited_rd_address (commited_rd_address),
        .outstanding         (outstanding),
        .proto_err           (proto_err)
`ifdef RX_COMMIT_STATS_EN
        ,
        .commit_cnt          (commit_cnt),
        .max_wait            (max_wait)
`endif
    );

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        addr_t a;
        int    e;
    } exp_t;

    exp_t exq[$];

    // Reference model: in-order queue of live tags plus commit bookkeeping.
    int    mq[$];
    bit    m_done [NT];
    addr_t m_end  [NT];
    int    m_wr;
    addr_t m_staged;
    addr_t m_comm;
    int    m_wait;
    int    m_gap_left;
    bit    m_fp;
    bit    m_err;
    int    m_ncommit;
    int    m_maxwait;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < NT; i++) begin
            m_done[i] = 1'b0;
            m_end[i]  = '0;
        end
        m_wr = 0; m_staged = '0; m_comm = '0;
        m_wait = 0; m_gap_left = 0; m_fp = 0; m_err = 0;
        m_ncommit = 0; m_maxwait = 0;
    endtask

    function automatic bit in_q(input int t);
        foreach (mq[i]) if (mq[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    // Advance the model across one clock edge using pre-edge state.
    task automatic model_edge(input bit gnt, input addr_t a, input bit dv,
                              input logic [1:0] dt, input bit fl);
        addr_t diff;
        bit    ok_done;
        bit    ret;
        diff    = addr_t'(m_staged - m_comm);
        ok_done = dv && in_q(int'(dt)) && !m_done[dt];
        ret     = (mq.size() > 0) && m_done[mq[0]];
        if (m_gap_left == 0) begin
            if (diff != 0 && (diff >= 64 || m_wait == 255 || m_fp)) begin
                exq.push_back('{m_staged, edge_cnt + 1});
                if (m_wait > m_maxwait) m_maxwait = m_wait;
                m_comm = m_staged;
                m_wait = 0;
                m_gap_left = 8;
                m_fp = 0;
                m_ncommit++;
            end else if (diff != 0) begin
                if (m_wait < 255) m_wait++;
                m_fp = m_fp | fl;
            end else begin
                m_wait = 0;
                m_fp = 0;
            end
        end else begin
            m_gap_left--;
            m_fp = m_fp | fl;
        end
        if (dv && !ok_done) m_err = 1'b1;
        if (ret) begin
            m_staged = m_end[mq[0]];
            m_done[mq[0]] = 1'b0;
            void'(mq.pop_front());
        end
        if (ok_done) m_done[dt] = 1'b1;
        if (gnt) begin
            mq.push_back(m_wr);
            m_end[m_wr] = a;
            m_done[m_wr] = 1'b0;
            m_wr = (m_wr + 1) % NT;
        end
    endtask

    // Called just after a falling edge; returns after the next falling edge.
    task automatic step(input bit req, input addr_t a, input bit dv,
                        input logic [1:0] dt, input bit fl);
        bit gnt;
        alloc_req = req; alloc_end_addr = a;
        done_valid = dv; done_tag = dt; flush = fl;
        #1;
        gnt = req && (mq.size() < NT);
        chk("alloc_gnt", alloc_gnt, gnt);
        if (gnt) chk("alloc_tag", alloc_tag, m_wr);
        chk("outstanding", outstanding, mq.size());
        chk("proto_err", proto_err, m_err);
        model_edge(gnt, a, dv, dt, fl);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic monitor();
        addr_t prev = '0;
        exp_t  e;
        forever begin
            @(posedge clk);
            #2;
            if (!reset_n) begin
                prev = '0;
            end else begin
                if (commited_rd_address !== prev) begin
                    if (exq.size() == 0) begin
                        chk("spurious_commit", commited_rd_address, prev);
                    end else begin
                        e = exq.pop_front();
                        chk("commit_addr", commited_rd_address, e.a);
                        chk("commit_edge", edge_cnt, e.e);
                    end
                    prev = commited_rd_address;
                end
                while (exq.size() > 0 && exq[0].e <= edge_cnt) begin
                    e = exq.pop_front();
                    chk("missed_commit", commited_rd_address, e.a);
                end
            end
        end
    endtask

    initial begin
        addr_t next_addr;
        int    pend[$];
        bit    req;
        bit    dv;
        logic [1:0] dt;

        reset_n = 1'b0;
        alloc_req = 0; alloc_end_addr = '0;
        done_valid = 0; done_tag = '0; flush = 0;
        model_reset();
        fork
            monitor();
        join_none

        @(negedge clk);
        @(negedge clk);
        chk("rst_commit", commited_rd_address, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_gnt", alloc_gnt, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Fill the table, then one more request while full.
        step(1, 16, 0, 0, 0);
        step(1, 32, 0, 0, 0);
        step(1, 48, 0, 0, 0);
        step(1, 64, 0, 0, 0);
        step(1, 80, 0, 0, 0);
        chk("full_gnt", alloc_gnt, 0);
        chk("full_outstanding", outstanding, 4);

        // Out-of-order completion; head blocks retirement until done.
        step(0, 0, 1, 2, 0);
        step(0, 0, 1, 1, 0);
        idle(3);
        chk("ooo_no_retire", outstanding, 4);
        step(0, 0, 1, 0, 0);
        idle(250);
        chk("pre_timeout", commited_rd_address, 0);
        idle(10);
        chk("timeout_commit", commited_rd_address, 48);
        chk("ooo_left", outstanding, 1);

        // Threshold: diff reaches 64 right after a retire.
        step(0, 0, 1, 3, 0);
        idle(1);
        step(1, 112, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        idle(1);
        chk("thr_before", commited_rd_address, 48);
        idle(1);
        chk("thr_commit", commited_rd_address, 112);

        // Flush during GAP commits on the first IDLE cycle.
        step(1, 128, 0, 0, 0);
        step(0, 0, 1, 1, 1);
        idle(6);
        chk("gap_hold", commited_rd_address, 112);
        idle(1);
        chk("flush_commit", commited_rd_address, 128);

        // Flush with nothing staged is dropped.
        idle(20);
        step(0, 0, 0, 0, 1);
        idle(20);
        chk("flush_nodiff", commited_rd_address, 128);
        step(1, 136, 0, 0, 0);
        step(0, 0, 1, 2, 0);
        idle(4);
        chk("flush_cleared", commited_rd_address, 128);

        // Completion for an unallocated tag.
        chk("err_before", proto_err, 0);
        step(0, 0, 1, 3, 0);
        chk("err_set", proto_err, 1);
        chk("err_table", outstanding, 0);

        // Asynchronous reset in the middle of a batch.
        step(1, 200, 0, 0, 0);
        step(1, 210, 0, 0, 0);
        step(0, 0, 1, 3, 0);
        idle(1);
        #3;
        reset_n = 1'b0;
        alloc_req = 0; done_valid = 0; flush = 0;
        #1;
        chk("async_commit", commited_rd_address, 0);
        chk("async_outstanding", outstanding, 0);
        chk("async_err", proto_err, 0);
        exq.delete();
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // Address wrap-around.
        step(1, addr_t'(16'hFFF0), 0, 0, 0);
        step(0, 0, 1, 0, 0);
        idle(2);
        chk("wrap_pre", commited_rd_address, addr_t'(16'hFFF0));
        step(1, addr_t'(16'h0030), 0, 0, 0);
        step(0, 0, 1, 1, 0);
        idle(11);
        chk("wrap_commit", commited_rd_address, addr_t'(16'h0030));

        // Random traffic.
        next_addr = addr_t'(16'h0040);
        repeat (3000) begin
            req = ($urandom_range(0, 99) < 40);
            dv  = 1'b0;
            dt  = '0;
            pend.delete();
            foreach (mq[i]) if (!m_done[mq[i]]) pend.push_back(mq[i]);
            if (pend.size() > 0 && $urandom_range(0, 99) < 35) begin
                dv = 1'b1;
                dt = 2'(pend[$urandom_range(0, pend.size() - 1)]);
            end
            if (req && mq.size() < NT) begin
                step(req, next_addr, dv, dt, ($urandom_range(0, 99) < 3));
                if ($urandom_range(0, 9) == 0)
                    next_addr = next_addr + addr_t'($urandom_range(2000, 9000));
                else
                    next_addr = next_addr + addr_t'($urandom_range(1, 40));
            end else begin
                step(req, next_addr, dv, dt, ($urandom_range(0, 99) < 3));
            end
        end

        // Complete everything and let timeouts drain the staged advance.
        for (int k = 0; k < 2 * NT; k++) begin
            pend.delete();
            foreach (mq[i]) if (!m_done[mq[i]]) pend.push_back(mq[i]);
            if (pend.size() > 0) step(0, 0, 1, 2'(pend[0]), 0);
            else idle(1);
        end
        idle(300);
        chk("drain_queue", exq.size(), 0);
        chk("drain_commit", commited_rd_address, m_comm);
        chk("drain_outstanding", outstanding, 0);
`ifdef RX_COMMIT_STATS_EN
        chk("commit_cnt", commit_cnt, m_ncommit);
        chk("max_wait", max_wait, m_maxwait);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_rd_commit_ctrl.md
Name: rx_rd_commit_ctrl

Overview:
- In-order commit scheduler for the RX buffer read pointer. Placed upstream of the read-address clock-domain synchronizer.
- Issues tags to outstanding frame reads and accepts completions out of order. Retires them strictly in allocation order.
- Batches the resulting read-address advances and drives the committed address no faster than the synchronizer handshake can absorb.

Parameters:
- TAG_W, 2, tag width; table depth NT = 2^TAG_W.
- BATCH_THRESH, 64, advance in address units that forces a commit.
- TIMEOUT, 255, max cycles a nonzero uncommitted advance may wait.
- MIN_GAP, 8, minimum cycles between successive commit updates (must be >= synchronizer cycle length).
- Address width is `BF+1, from includes.v.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- alloc_req  in  1  consumer requests a tag for a new frame read.
- alloc_end_addr  in  `BF+1  buffer address immediately after that frame.
- alloc_gnt  out  1  combinational grant = alloc_req & ~full.
- alloc_tag  out  TAG_W  tag issued (current write pointer); valid with alloc_gnt.
- done_valid  in  1  a frame read has completed.
- done_tag  in  TAG_W  tag of the completed read.
- flush  in  1  pulse: commit all retired advance as soon as allowed.
- commited_rd_address  out  `BF+1  to synchronizer input; reset 0.
- outstanding  out  TAG_W+1  entries in table; reset 0.
- proto_err  out  1  sticky; reset 0.

Behaviour:
- Table of NT entries, each {valid, done, end_addr}. Pointers wr_ptr and rd_ptr are TAG_W bits and wrap modulo NT. count is 0..NT. full = (count==NT), evaluated from registered state at cycle start.
- Allocate:
  - On alloc_gnt: entry[wr_ptr] <= {1,0,alloc_end_addr}; wr_ptr++.
  - A request while full is not granted. The requester holds alloc_req.
- Complete:
  - On done_valid with entry[done_tag].valid=1: done <= 1.
  - If the entry is not valid, or done is already 1: ignore and set proto_err.
- Retire:
  - At most one per cycle. If entry[rd_ptr].valid & done: staged_addr <= end_addr; entry cleared; rd_ptr++.
  - A completion arriving this cycle for the rd_ptr entry retires next cycle, giving 1 cycle from done to staged.
- count: +1 on alloc, -1 on retire, unchanged when both happen in one cycle. A retire in a full cycle does not enable alloc in that same cycle.
- diff = (staged_addr - commited_rd_address) mod 2^(`BF+1). Arithmetic is unsigned and wraps.
- Commit FSM states:
  - IDLE:
    - If diff != 0 and (diff >= BATCH_THRESH or timer == TIMEOUT or flush_pending): commited_rd_address <= staged_addr; timer <= 0; gap <= 0; go to GAP.
    - Else if diff != 0: timer++, saturating at TIMEOUT.
    - Else: timer <= 0.
  - GAP: gap++. Leave for IDLE when gap == MIN_GAP-1, so commits are spaced >= MIN_GAP cycles. Timer holds at 0.
- flush_pending:
  - Set by a flush pulse in any state.
  - Cleared in IDLE when a commit issues, or when diff == 0.
  - flush and clear in the same cycle: set wins if the flush arrives while in GAP.
- Latency: retire to commit is 1 cycle when a condition already holds in IDLE. Otherwise it waits for the threshold, timeout, or flush.
- Reset mid-operation: table, pointers, count, timer, gap, flush_pending, staged_addr, commited_rd_address and proto_err all clear to 0. The FSM goes to IDLE. Outstanding reads are discarded.
- commited_rd_address changes only on a commit edge. It is never written in GAP.

Optional Feature:
- RX_COMMIT_STATS_EN defined:
  - Adds output commit_cnt [31:0]: +1 per commit, wraps, reset 0.
  - Adds output max_wait [15:0]: highest timer value seen at a commit, saturating.
- RX_COMMIT_STATS_EN undefined: neither port nor the counters exist. All other behaviour is identical.

Test Plan:
- Full table: alloc 4 tags (end 16,32,48,64) -> tags 0..3; 5th req with no retire -> gnt=0, outstanding=4.
- Out-of-order completion: done 2, then 1, then 0 -> no retire until tag 0 is done; then 3 retires on consecutive cycles, staged=48; diff=48<64 -> commit 48 after 256 cycles (timeout).
- Batch threshold: all tags done, end 64 -> commited_rd_address=64 one cycle after the retire. Second advance to 80 immediately after -> not committed before 8 cycles (MIN_GAP).
- Wrap-around: committed=0x..FFF0 (max-16), retire to 0x0030 -> diff=64, commit issues; tag pointers wrap 3->0 with no loss.
- Flush: staged diff=8, flush pulse in GAP -> commit on first IDLE cycle. Flush with diff=0 -> no commit, flush_pending cleared.
- Protocol error and reset: done for an unallocated tag -> proto_err=1, table unchanged. reset_n low mid-batch -> all outputs 0 the same cycle (async).
